// File: rtl/serial_uart_bridge_pkg.sv
// Shared definitions for the serial UART bridge:
// FSM state encoding and default bit timing.
package serial_bridge_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/serial_fifo.sv
// Synchronous FIFO with registered full/empty flags
// and a registered show-ahead head output.
module serial_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [AW:0]      wptr_n;
    logic [AW:0]      rptr_n;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign wptr_n  = wptr + {{AW{1'b0}}, do_push};
    assign rptr_n  = rptr + {{AW{1'b0}}, do_pop};

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    // Head is refreshed only while data remains, so it holds once drained.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
            rdata <= '0;
        end else begin
            wptr  <= wptr_n;
            rptr  <= rptr_n;
            empty <= (wptr_n == rptr_n);
            full  <= (wptr_n[AW] != rptr_n[AW]) &&
                     (wptr_n[AW-1:0] == rptr_n[AW-1:0]);
            if (wptr_n != rptr_n) begin
                if (do_push && (wptr[AW-1:0] == rptr_n[AW-1:0])) begin
                    rdata <= wdata;
                end else begin
                    rdata <= mem[rptr_n[AW-1:0]];
                end
            end
        end
    end

endmodule

// File: rtl/serial_uart_bridge.sv
// Core-side byte queues bridged to an 8N1 UART line,
// with sticky drop/error flags.
module serial_uart_bridge
    import serial_bridge_defs::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_AW      = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] cpu_data_in,
    input  logic       cpu_wren_in,
    input  logic       cpu_rden_in,
    output logic [7:0] cpu_data_out,
    output logic       cpu_valid_out,
    output logic       cpu_ready_out,
    input  logic       uart_rx_in,
    output logic       uart_tx_out,
    output logic       tx_overflow_out,
    output logic       rx_overrun_out,
    output logic       rx_framing_err_out
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic [7:0]  tx_head;
    logic        tx_full;
    logic        tx_empty;
    logic        tx_pop;
    uart_state_t tx_state;
    uart_state_t tx_state_n;
    logic [CW-1:0] tx_cnt;
    logic [CW-1:0] tx_cnt_n;
    logic [2:0]  tx_bit;
    logic [2:0]  tx_bit_n;
    logic [7:0]  tx_sh;
    logic [7:0]  tx_sh_n;
    logic        tx_line;
    logic        tx_line_n;

    serial_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (cpu_wren_in),
        .wdata (cpu_data_in),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_sh    <= tx_sh_n;
            tx_line  <= tx_line_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_sh_n    = tx_sh;
        tx_line_n  = tx_line;
        tx_pop     = 1'b0;
        unique case (tx_state)
            ST_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_sh_n    = tx_head;
                    tx_line_n  = 1'b0;
                    tx_cnt_n   = '0;
                    tx_state_n = ST_START;
                end
            end
            ST_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_line_n  = tx_sh[0];
                    tx_state_n = ST_DATA;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_bit == 3'd7) begin
                        tx_line_n  = 1'b1;
                        tx_state_n = ST_STOP;
                    end else begin
                        tx_bit_n  = tx_bit + 1'b1;
                        tx_sh_n   = tx_sh >> 1;
                        tx_line_n = tx_sh[1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    // Chain straight into the next start bit when queued.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_sh_n    = tx_head;
                        tx_line_n  = 1'b0;
                        tx_state_n = ST_START;
                    end else begin
                        tx_state_n = ST_IDLE;
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            default: tx_state_n = ST_IDLE;
        endcase
    end

    logic [1:0]  rx_sync;
    logic        rx_s;
    logic        rx_full;
    logic        rx_empty;
    logic        rx_push;
    logic        set_overrun;
    logic        set_framing;
    uart_state_t rx_state;
    uart_state_t rx_state_n;
    logic [CW-1:0] rx_cnt;
    logic [CW-1:0] rx_cnt_n;
    logic [2:0]  rx_bit;
    logic [2:0]  rx_bit_n;
    logic [7:0]  rx_sh;
    logic [7:0]  rx_sh_n;

    assign rx_s = rx_sync[1];

    serial_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_push),
        .wdata (rx_sh),
        .pop   (cpu_rden_in),
        .rdata (cpu_data_out),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_sync  <= 2'b11;
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_sync  <= {rx_sync[0], uart_rx_in};
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_sh    <= rx_sh_n;
        end
    end

    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt;
        rx_bit_n    = rx_bit;
        rx_sh_n     = rx_sh;
        rx_push     = 1'b0;
        set_overrun = 1'b0;
        set_framing = 1'b0;
        unique case (rx_state)
            ST_IDLE: begin
                if (!rx_s) begin
                    rx_cnt_n   = '0;
                    rx_state_n = ST_START;
                end
            end
            ST_START: begin
                // Mid-bit recheck rejects short glitches.
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n = '0;
                    rx_sh_n  = {rx_s, rx_sh[7:1]};
                    if (rx_bit == 3'd7) begin
                        rx_state_n = ST_STOP;
                    end else begin
                        rx_bit_n = rx_bit + 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_state_n = ST_IDLE;
                    if (!rx_s) begin
                        set_framing = 1'b1;
                    end else if (rx_full) begin
                        set_overrun = 1'b1;
                    end else begin
                        rx_push = 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            default: rx_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_overflow_out    <= 1'b0;
            rx_overrun_out     <= 1'b0;
            rx_framing_err_out <= 1'b0;
        end else begin
            if (cpu_wren_in && tx_full) tx_overflow_out <= 1'b1;
            if (set_overrun) rx_overrun_out <= 1'b1;
            if (set_framing) rx_framing_err_out <= 1'b1;
        end
    end

    assign uart_tx_out   = tx_line;
    assign cpu_valid_out = !rx_empty;
    assign cpu_ready_out = !tx_full;

endmodule

// File: tb/tb_serial_uart_bridge.sv
// Directed bench for serial_uart_bridge at 4 clocks/bit,
// 16-deep FIFOs.
module tb_serial_uart_bridge;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] cpu_data_in = 8'h00;
    logic       cpu_wren_in = 1'b0;
    logic       cpu_rden_in = 1'b0;
    logic [7:0] cpu_data_out;
    logic       cpu_valid_out;
    logic       cpu_ready_out;
    logic       uart_rx_in = 1'b1;
    logic       uart_tx_out;
    logic       tx_overflow_out;
    logic       rx_overrun_out;
    logic       rx_framing_err_out;

    int n_checks = 0;
    int n_errors = 0;

    serial_uart_bridge #(.CLKS_PER_BIT(4), .FIFO_AW(4)) dut (
        .clock              (clock),
        .reset              (reset),
        .cpu_data_in        (cpu_data_in),
        .cpu_wren_in        (cpu_wren_in),
        .cpu_rden_in        (cpu_rden_in),
        .cpu_data_out       (cpu_data_out),
        .cpu_valid_out      (cpu_valid_out),
        .cpu_ready_out      (cpu_ready_out),
        .uart_rx_in         (uart_rx_in),
        .uart_tx_out        (uart_tx_out),
        .tx_overflow_out    (tx_overflow_out),
        .rx_overrun_out     (rx_overrun_out),
        .rx_framing_err_out (rx_framing_err_out)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    // Starts one cycle before the start bit; ends on the last stop cycle.
    task automatic tx_frame(input logic [7:0] d);
        logic [9:0] f;
        f = {1'b1, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                chk($sformatf("txbit_%0h_%0d", d, k), uart_tx_out, f[k]);
            end
        end
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            uart_rx_in = f[k];
            repeat (4) tick();
        end
        uart_rx_in = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        // 1: reset state
        do_reset();
        chk("rst_tx", uart_tx_out, 1);
        chk("rst_ready", cpu_ready_out, 1);
        chk("rst_valid", cpu_valid_out, 0);
        chk("rst_data", cpu_data_out, 0);
        chk("rst_flags", {tx_overflow_out, rx_overrun_out,
                          rx_framing_err_out}, 0);

        // 2: single byte 0x55, falls one edge after the write edge
        cpu_data_in = 8'h55;
        cpu_wren_in = 1'b1;
        tick();
        cpu_wren_in = 1'b0;
        chk("tx_at_e", uart_tx_out, 1);
        tx_frame(8'h55);
        repeat (8) begin
            tick();
            chk("tx_idle_after", uart_tx_out, 1);
        end

        // 3: 18 writes, 17 contiguous frames, last write dropped
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    cpu_data_in = 8'(i);
                    cpu_wren_in = 1'b1;
                    tick();
                    if (i == 15) chk("ready_16", cpu_ready_out, 1);
                    if (i == 16) begin
                        chk("ready_17", cpu_ready_out, 0);
                        chk("ovf_pre", tx_overflow_out, 0);
                    end
                end
                cpu_wren_in = 1'b0;
                chk("tx_ovf", tx_overflow_out, 1);
            end
            begin
                tick();
                for (int f = 0; f < 17; f++) tx_frame(8'(f));
            end
        join
        repeat (8) begin
            tick();
            chk("tx_idle_17", uart_tx_out, 1);
        end
        chk("ready_end", cpu_ready_out, 1);
        chk("ovf_sticky", tx_overflow_out, 1);

        // 4: receive 0xA3 and consume it
        rx_frame(8'hA3, 1'b1);
        chk("rx_valid", cpu_valid_out, 1);
        chk("rx_data", cpu_data_out, 8'hA3);
        cpu_rden_in = 1'b1;
        tick();
        cpu_rden_in = 1'b0;
        chk("rx_valid_pop", cpu_valid_out, 0);
        chk("rx_data_hold", cpu_data_out, 8'hA3);

        // 5: framing error, then a 1-cycle glitch, then recovery
        rx_frame(8'h3C, 1'b0);
        repeat (10) tick();
        chk("ferr", rx_framing_err_out, 1);
        chk("ferr_valid", cpu_valid_out, 0);
        uart_rx_in = 1'b0;
        tick();
        uart_rx_in = 1'b1;
        repeat (60) tick();
        chk("glitch_valid", cpu_valid_out, 0);
        rx_frame(8'h5A, 1'b1);
        chk("recov_valid", cpu_valid_out, 1);
        chk("recov_data", cpu_data_out, 8'h5A);

        // 6: overrun after 16 queued bytes
        do_reset();
        chk("rst2_flags", {tx_overflow_out, rx_overrun_out,
                           rx_framing_err_out}, 0);
        for (int i = 0; i < 17; i++) begin
            if (i == 16) chk("ovr_pre", rx_overrun_out, 0);
            rx_frame(8'h80 + 8'(i), 1'b1);
        end
        chk("ovr", rx_overrun_out, 1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("q_valid_%0d", i), cpu_valid_out, 1);
            chk($sformatf("q_data_%0d", i), cpu_data_out, 8'h80 + 8'(i));
            cpu_rden_in = 1'b1;
            tick();
            cpu_rden_in = 1'b0;
        end
        chk("q_empty", cpu_valid_out, 0);
        cpu_rden_in = 1'b1;
        tick();
        cpu_rden_in = 1'b0;
        chk("empty_rd_data", cpu_data_out, 8'h8F);
        chk("empty_rd_valid", cpu_valid_out, 0);

        // reset mid TX frame with both FIFOs holding data
        rx_frame(8'h77, 1'b1);
        chk("pre_rst_valid", cpu_valid_out, 1);
        cpu_data_in = 8'hF0;
        cpu_wren_in = 1'b1;
        tick();
        cpu_data_in = 8'h0F;
        tick();
        cpu_wren_in = 1'b0;
        tick();
        chk("mid_tx_low", uart_tx_out, 0);
        reset = 1'b1;
        tick();
        chk("rst_edge_tx", uart_tx_out, 1);
        reset = 1'b0;
        tick();
        chk("rst3_valid", cpu_valid_out, 0);
        chk("rst3_data", cpu_data_out, 0);
        chk("rst3_ready", cpu_ready_out, 1);
        repeat (50) begin
            tick();
            chk("rst3_tx_idle", uart_tx_out, 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
